// File: rtl/sia_pkg.sv
// SIA transmitter shared definitions.
// State encoding and width helper.
package sia_pkg;

  typedef enum logic [1:0] {
    SIA_IDLE,
    SIA_LOAD,
    SIA_SHIFT
  } sia_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sia_transmitter_fifo_if.sv
// SIA transmitter CPU/pin bundle.
// master = CPU side and pins, slave = engine.
interface sia_transmitter_fifo_if
  import sia_pkg::*;
#(
  parameter int SW  = 16,
  parameter int BRW = 32,
  parameter int BW  = 5,
  parameter int FD  = 4
);
  localparam int LW = clog2(FD) + 1;

  logic [SW-1:0]  dat_i;
  logic           txreg_we_i;
  logic           txreg_oe_i;
  logic [BRW-1:0] txbaud_i;
  logic [BW-1:0]  bits_i;
  logic           msb_first_i;
  logic           rxd_i;
  logic           txd_o;
  logic           txc_o;
  logic           idle_o;
  logic           full_o;
  logic [LW-1:0]  level_o;
  logic           done_o;
  logic           ovf_o;
  logic [BRW-1:0] brg_o;
  logic [BW-1:0]  bits_o;
  logic [SW-1:0]  dat_o;

  modport master (
    output dat_i, txreg_we_i, txreg_oe_i,
    output txbaud_i, bits_i, msb_first_i,
    output rxd_i,
    input  txd_o, txc_o, idle_o, full_o,
    input  level_o, done_o, ovf_o,
    input  brg_o, bits_o, dat_o
  );

  modport slave (
    input  dat_i, txreg_we_i, txreg_oe_i,
    input  txbaud_i, bits_i, msb_first_i,
    input  rxd_i,
    output txd_o, txc_o, idle_o, full_o,
    output level_o, done_o, ovf_o,
    output brg_o, bits_o, dat_o
  );
endinterface

// File: rtl/sia_tx_fifo.sv
// Transmit word queue, power-of-two depth.
// Head word is read combinationally.
module sia_tx_fifo
  import sia_pkg::*;
#(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // pointer and occupancy update
  always_comb begin
    wr_d  = wr_q + AW'(push_ok);
    rd_d  = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + LW'(push_ok) - LW'(pop_ok);
  end

  // control state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage needs no reset; reads are gated by occupancy
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/sia_transmitter_fifo.sv
// SIA transmit engine with queued words, BRG and bit clock.
// Define SIA_TX_LOOPBACK_EN to shift rxd_i into the vacated end.
module sia_transmitter_fifo
  import sia_pkg::*;
#(
  parameter int SHIFT_REG_WIDTH = 16,
  parameter int BAUD_RATE_WIDTH = 32,
  parameter int BITS_WIDTH      = 5,
  parameter int FIFO_DEPTH      = 4
) (
  input logic clk_i,
  input logic reset_ni,
  sia_transmitter_fifo_if.slave bus
);
  localparam int SW  = SHIFT_REG_WIDTH;
  localparam int BRW = BAUD_RATE_WIDTH;
  localparam int BW  = BITS_WIDTH;
  localparam int LW  = clog2(FIFO_DEPTH) + 1;

  sia_state_e     state_q, state_d;
  logic [SW-1:0]  sr_q, sr_d;
  logic [BRW-1:0] brg_q, brg_d;
  logic [BW-1:0]  bits_q, bits_d;
  logic           txc_q, txc_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;
  logic           msb_q, msb_d;

  logic           push, pop;
  logic [SW-1:0]  head;
  logic           full, empty;
  logic [LW-1:0]  level;
  logic [BW-1:0]  bits_ld;
  logic [BRW-1:0] half;
  logic           fill;

`ifdef SIA_TX_LOOPBACK_EN
  assign fill = bus.rxd_i;
`else
  logic unused_rxd;
  assign fill       = 1'b1;
  assign unused_rxd = bus.rxd_i;
`endif

  assign push    = bus.txreg_we_i & ~full;
  assign pop     = (state_q == SIA_LOAD);
  assign half    = {1'b0, bus.txbaud_i[BRW-1:1]};
  assign bits_ld = (bus.bits_i > BW'(SW)) ? BW'(SW)
                                          : bus.bits_i;

  sia_tx_fifo #(
    .W     (SW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.dat_i),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // sequencing, shifting, BRG and bit clock
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    brg_d   = brg_q;
    bits_d  = bits_q;
    txc_d   = txc_q;
    msb_d   = msb_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | (bus.txreg_we_i & full);
    unique case (1'b1)
      state_q == SIA_IDLE: begin
        if (!empty) state_d = SIA_LOAD;
      end
      state_q == SIA_LOAD: begin
        sr_d   = head;
        brg_d  = bus.txbaud_i;
        bits_d = bits_ld;
        msb_d  = bus.msb_first_i;
        txc_d  = (bits_ld != '0);
        if (bits_ld == '0) begin
          done_d  = 1'b1;
          state_d = SIA_IDLE;
        end else begin
          state_d = SIA_SHIFT;
        end
      end
      state_q == SIA_SHIFT: begin
        if (brg_q != '0) begin
          brg_d = brg_q - BRW'(1);
        end else begin
          sr_d   = msb_q ? {sr_q[SW-2:0], fill}
                         : {fill, sr_q[SW-1:1]};
          brg_d  = bus.txbaud_i;
          bits_d = bits_q - BW'(1);
          txc_d  = (bits_q != BW'(1));
          if (bits_q == BW'(1)) begin
            done_d  = 1'b1;
            state_d = empty ? SIA_IDLE : SIA_LOAD;
          end
        end
      end
      default: state_d = SIA_IDLE;
    endcase
    // compare the next count so the fall lands
    // on the true midpoint of the bit period
    if (brg_d == half) txc_d = 1'b0;
  end

  // engine registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= SIA_IDLE;
      sr_q    <= '1;
      brg_q   <= '0;
      bits_q  <= '0;
      txc_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      brg_q   <= brg_d;
      bits_q  <= bits_d;
      txc_q   <= txc_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      msb_q   <= msb_d;
    end
  end

  assign bus.txd_o   = msb_q ? sr_q[SW-1] : sr_q[0];
  assign bus.txc_o   = txc_q;
  assign bus.idle_o  = (bits_q == '0) & empty &
                       (state_q != SIA_LOAD);
  assign bus.full_o  = full;
  assign bus.level_o = level;
  assign bus.done_o  = done_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.brg_o   = brg_q;
  assign bus.bits_o  = bits_q;
  assign bus.dat_o   = bus.txreg_oe_i ? sr_q : '0;
endmodule

// File: tb/tb_sia_transmitter_fifo.sv
// Bench for sia_transmitter_fifo.
// Frame timing predicted from bit index and period.
module tb_sia_transmitter_fifo;
  import sia_pkg::*;

  localparam int SW  = 16;
  localparam int BRW = 32;
  localparam int BW  = 5;
  localparam int FD  = 4;
  localparam int LW  = clog2(FD) + 1;

`ifdef SIA_TX_LOOPBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  sia_transmitter_fifo_if #(
    .SW(SW), .BRW(BRW), .BW(BW), .FD(FD)
  ) bus ();

  assign bus.rxd_i = bus.txd_o;

  sia_transmitter_fifo #(
    .SHIFT_REG_WIDTH (SW),
    .BAUD_RATE_WIDTH (BRW),
    .BITS_WIDTH      (BW),
    .FIFO_DEPTH      (FD)
  ) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus.slave)
  );

  // shift register contents after n bits, rxd tied to txd
  function automatic logic [SW-1:0] sr_after(
    input logic [SW-1:0] w, input int n, input bit msb);
    logic [SW-1:0] s;
    logic b;
    s = w;
    for (int k = 0; k < n; k++) begin
      b = msb ? s[SW-1] : s[0];
      if (!LOOP) b = 1'b1;
      s = msb ? {s[SW-2:0], b} : {b, s[SW-1:1]};
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [SW-1:0] w);
    bus.dat_i      = w;
    bus.txreg_we_i = 1'b1;
    tick();
    bus.txreg_we_i = 1'b0;
  endtask

  // entered just after the edge that shows the first bit
  task automatic run_frame(input logic [SW-1:0] w,
    input int n, input bit msb, input int p,
    input bit exp_idle);
    int k;
    logic et;
    for (int c = 0; c < n * p; c++) begin
      k  = c / p;
      et = msb ? w[SW-1-k] : w[k];
      vecs++;
      if (bus.txd_o !== et) begin
        errs++;
        $display("FAIL txd c=%0d: got %b want %b", c, bus.txd_o, et);
      end
      vecs++;
      if (bus.txc_o !== ((c % p) < (p / 2))) begin
        errs++;
        $display("FAIL txc c=%0d p=%0d: got %b", c, p, bus.txc_o);
      end
      vecs++;
      if (bus.bits_o !== BW'(n - k)) begin
        errs++;
        $display("FAIL bits c=%0d: got %0d want %0d", c, bus.bits_o, n - k);
      end
      vecs++;
      if (bus.brg_o !== BRW'(p - 1 - (c % p))) begin
        errs++;
        $display("FAIL brg c=%0d: got %0d want %0d", c, bus.brg_o, p - 1 - (c % p));
      end
      vecs++;
      if (bus.done_o !== 1'b0) begin
        errs++;
        $display("FAIL early_done c=%0d: got %b want 0", c, bus.done_o);
      end
      tick();
    end
    vecs++;
    if (bus.done_o !== 1'b1) begin
      errs++;
      $display("FAIL done: got %b want 1", bus.done_o);
    end
    vecs++;
    if (bus.bits_o !== '0 || bus.txc_o !== 1'b0) begin
      errs++;
      $display("FAIL end_bits_txc: got %0d/%b want 0/0", bus.bits_o, bus.txc_o);
    end
    vecs++;
    if (bus.dat_o !== sr_after(w, n, msb)) begin
      errs++;
      $display("FAIL dat_o: got %h want %h", bus.dat_o, sr_after(w, n, msb));
    end
    vecs++;
    if (bus.idle_o !== exp_idle) begin
      errs++;
      $display("FAIL end_idle: got %b want %b", bus.idle_o, exp_idle);
    end
  endtask

  // one frame from an idle, empty block
  task automatic send(input logic [SW-1:0] w, input int nraw,
    input bit msb, input int baud);
    int n;
    n = (nraw > SW) ? SW : nraw;
    bus.bits_i      = BW'(nraw);
    bus.msb_first_i = msb;
    bus.txbaud_i    = BRW'(baud);
    bus.txreg_oe_i  = 1'b1;
    push(w);
    vecs++;
    if (bus.level_o !== LW'(1) || bus.idle_o !== 1'b0) begin
      errs++;
      $display("FAIL push_level: got %0d/%b want 1/0", bus.level_o, bus.idle_o);
    end
    tick();
    vecs++;
    if (bus.bits_o !== '0 || bus.idle_o !== 1'b0 || bus.level_o !== LW'(1)) begin
      errs++;
      $display("FAIL load: got bits %0d idle %b lvl %0d want 0 0 1", bus.bits_o, bus.idle_o, bus.level_o);
    end
    tick();
    run_frame(w, n, msb, baud + 1, 1'b1);
    tick();
    vecs++;
    if (bus.done_o !== 1'b0) begin
      errs++;
      $display("FAIL done_pulse: got %b want 0", bus.done_o);
    end
  endtask

  task automatic test_reset();
    bus.dat_i = '0; bus.txreg_we_i = 0; bus.txreg_oe_i = 1;
    bus.txbaud_i = '0; bus.bits_i = '0; bus.msb_first_i = 0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vecs++;
    if ({bus.txd_o, bus.txc_o, bus.idle_o, bus.full_o, bus.done_o, bus.ovf_o} !== 6'b101000) begin
      errs++;
      $display("FAIL reset_flags: got %b want 101000",
        {bus.txd_o, bus.txc_o, bus.idle_o, bus.full_o, bus.done_o, bus.ovf_o});
    end
    vecs++;
    if (bus.brg_o !== '0 || bus.bits_o !== '0 || bus.level_o !== '0) begin
      errs++;
      $display("FAIL reset_cnt: got %0d %0d %0d want 0 0 0", bus.brg_o, bus.bits_o, bus.level_o);
    end
    vecs++;
    if (bus.dat_o !== 16'hFFFF) begin
      errs++;
      $display("FAIL reset_dat: got %h want ffff", bus.dat_o);
    end
  endtask

  task automatic test_lsb();
    send(16'h00A5, 8, 1'b0, 3);
    bus.txreg_oe_i = 1'b0;
    #1;
    vecs++;
    if (bus.dat_o !== '0) begin
      errs++;
      $display("FAIL dat_oe0: got %h want 0", bus.dat_o);
    end
    bus.txreg_oe_i = 1'b1;
  endtask

  task automatic test_msb();
    send(16'hF000, 4, 1'b1, 2);
  endtask

  task automatic test_loopback();
    send(16'h1234, 16, 1'b0, 1);
  endtask

  task automatic test_baud0();
    send(16'h0002, 2, 1'b0, 0);
    send(16'h5A5A, 20, 1'b1, 0);
    send(16'hBEEF, 0, 1'b0, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      send(SW'($urandom), int'($urandom_range(0, 20)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] q [5];
    bit msb;
    msb = 1'($urandom_range(0, 1));
    bus.bits_i = BW'(8);
    bus.msb_first_i = msb;
    bus.txbaud_i = BRW'(3);
    push(SW'($urandom));
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      q[i] = SW'($urandom);
      bus.dat_i = q[i];
      bus.txreg_we_i = 1'b1;
      tick();
    end
    bus.txreg_we_i = 1'b0;
    vecs++;
    if (bus.level_o !== LW'(4) || bus.full_o !== 1'b1 || bus.ovf_o !== 1'b1) begin
      errs++;
      $display("FAIL b2b_full: got lvl %0d full %b ovf %b want 4 1 1", bus.level_o, bus.full_o, bus.ovf_o);
    end
    for (int t = 0; t < 200 && bus.done_o !== 1'b1; t++) tick();
    vecs++;
    if (bus.done_o !== 1'b1) begin
      errs++;
      $display("FAIL b2b_timeout: got done %b want 1", bus.done_o);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (bus.level_o !== LW'(4 - i) || bus.idle_o !== 1'b0) begin
        errs++;
        $display("FAIL b2b_load%0d: got lvl %0d idle %b want %0d 0", i, bus.level_o, bus.idle_o, 4 - i);
      end
      tick();
      run_frame(q[i], 8, msb, 4, i == 3);
    end
    tick();
    vecs++;
    if (bus.ovf_o !== 1'b1 || bus.level_o !== '0) begin
      errs++;
      $display("FAIL b2b_after: got ovf %b lvl %0d want 1 0", bus.ovf_o, bus.level_o);
    end
  endtask

  task automatic test_reset_midframe();
    bus.bits_i = BW'(8);
    bus.msb_first_i = 1'b0;
    bus.txbaud_i = BRW'(3);
    push(16'h0000);
    tick();
    push(16'h1111);
    push(16'h2222);
    for (int t = 0; t < 100 && bus.bits_o !== BW'(3); t++) tick();
    vecs++;
    if (bus.bits_o !== BW'(3)) begin
      errs++;
      $display("FAIL mid_timeout: got bits %0d want 3", bus.bits_o);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.txd_o, bus.txc_o, bus.idle_o, bus.full_o, bus.done_o, bus.ovf_o} !== 6'b101000) begin
      errs++;
      $display("FAIL mid_flags: got %b want 101000",
        {bus.txd_o, bus.txc_o, bus.idle_o, bus.full_o, bus.done_o, bus.ovf_o});
    end
    vecs++;
    if (bus.brg_o !== '0 || bus.bits_o !== '0 || bus.level_o !== '0) begin
      errs++;
      $display("FAIL mid_cnt: got %0d %0d %0d want 0 0 0", bus.brg_o, bus.bits_o, bus.level_o);
    end
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      vecs++;
      if (bus.done_o !== 1'b0 || bus.idle_o !== 1'b1) begin
        errs++;
        $display("FAIL mid_after%0d: got done %b idle %b want 0 1", t, bus.done_o, bus.idle_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb();
    test_msb();
    test_loopback();
    test_baud0();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
